// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Definitions shared by the instruction fetch path and the rest of the CPU:
//   the default machine word width and the fetch FSM state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

   // Default instruction / address width used across the CPU.
   localparam int FU_WORD_SIZE = 16;

   // Fetch controller states. HALTED is terminal until reset.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Instruction memory request bus between the fetch unit (master) and the
//   instruction memory (slave). One request is outstanding at a time: the
//   master holds readM1/address1 until the slave answers with mem_ready.
//
//   readM1    master -> slave  read request
//   address1  master -> slave  fetch address
//   mem_ready slave  -> master data1 valid this cycle, completes the request
//   data1     slave  -> master fetched instruction word
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
   parameter int WORD_SIZE = fetch_unit_pkg::FU_WORD_SIZE
);

   logic                 readM1;
   logic [WORD_SIZE-1:0] address1;
   logic                 mem_ready;
   logic [WORD_SIZE-1:0] data1;

   modport master (
      output readM1,
      output address1,
      input  mem_ready,
      input  data1
   );

   modport slave (
      input  readM1,
      input  address1,
      output mem_ready,
      output data1
   );

endinterface : fetch_unit_if

// File: rtl/fetch_unit_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Circular FIFO of WIDTH x DEPTH (DEPTH a power of two, >= 2) used as the
//   instruction prefetch queue. Pointers wrap naturally modulo DEPTH.
//
//   Clk, Reset_N  clock, asynchronous active-low reset
//   push          write push_data at the tail (ignored when full or flushing)
//   push_data     entry to write
//   pop           drop the head entry (ignored when empty)
//   flush         empty the queue; wins over push and pop
//   head_data     current head entry (storage content, valid when count != 0)
//   count         number of occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             Clk,
   input  logic             Reset_N,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign do_push   = push && !flush && (count_q != FULL_CNT);
   assign do_pop    = pop  && !flush && (count_q != '0);
   assign head_data = storage[rd_ptr];
   assign count     = count_q;

   // NOTE: the storage array is reset on purpose so the head reads as zero out
   // of reset; that costs a reset net on every bit, so it is not done by habit.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            storage[i] <= '0;
         end
      end else if (do_push) begin
         storage[wr_ptr] <= push_data;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register in
   // the design samples pre-edge values, independent of block ordering.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // Simultaneous push and pop leaves the occupancy unchanged.
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction prefetcher. Issues one read at a time on the instruction bus,
//   buffers returned words with their addresses in a DEPTH-entry queue and
//   presents the head to the decoder. A redirect flushes the queue and restarts
//   fetching at redirect_pc; halt parks the unit in HALTED until reset, while
//   already queued words stay consumable.
//
//   Clk, Reset_N  clock, asynchronous active-low reset
//   imem          instruction memory bus (master side: readM1, address1,
//                 mem_ready, data1)
//   redirect      branch/jump taken: flush and refetch from redirect_pc
//   redirect_pc   new fetch address
//   inst_valid    queue head valid
//   instruction   queue head word
//   inst_pc       address of the queue head word
//   inst_accept   consumer takes the head this cycle
//   halt          stop issuing fetches
//   num_inst      count of accepted instructions (wraps)
//   is_halted     unit is in HALTED
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                   WORD_SIZE = FU_WORD_SIZE,
   parameter int                   DEPTH     = 4,
   parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
   input  logic                 Clk,
   input  logic                 Reset_N,
   fetch_unit_if.master         imem,
   input  logic                 redirect,
   input  logic [WORD_SIZE-1:0] redirect_pc,
   output logic                 inst_valid,
   output logic [WORD_SIZE-1:0] instruction,
   output logic [WORD_SIZE-1:0] inst_pc,
   input  logic                 inst_accept,
   input  logic                 halt,
   output logic [WORD_SIZE-1:0] num_inst,
   output logic                 is_halted
);

   localparam int               CNT_W    = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_state_t             state_q;
   fetch_state_t             state_d;
   logic [WORD_SIZE-1:0]     fetch_pc;
   logic [WORD_SIZE-1:0]     num_inst_q;
   logic                     q_push;
   logic                     q_pop;
   logic                     q_flush;
   logic [2*WORD_SIZE-1:0]   q_head;
   logic [CNT_W-1:0]         q_count;

   // ---------------------------------------------------------------------------
   // Fetch controller
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block gets a default before the case so no
   // path leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      q_push  = 1'b0;
      q_flush = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A redirect always flushes and reloads the PC; halt still wins
            // the state decision so the unit parks as soon as it is asked.
            q_flush = redirect;
            if (halt) begin
               state_d = HALTED;
            end else if (!redirect && (q_count != FULL_CNT)) begin
               state_d = REQ;
            end
         end
         REQ: begin
            // Halt is deliberately not looked at here: the outstanding read
            // must complete so address1 stays stable until mem_ready.
            if (redirect) begin
               q_flush = 1'b1;
               state_d = IDLE;
            end else if (imem.mem_ready) begin
               q_push  = 1'b1;
               state_d = IDLE;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The queue only pops; a redirect in the same cycle still counts the pop.
   assign q_pop = inst_valid && inst_accept;

   // ---------------------------------------------------------------------------
   // Fetch address and accepted-instruction counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         fetch_pc <= RESET_PC;
      end else if (q_flush) begin
         fetch_pc <= redirect_pc;
      end else if (q_push) begin
         fetch_pc <= fetch_pc + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         num_inst_q <= '0;
      end else if (q_pop) begin
         num_inst_q <= num_inst_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Prefetch queue: each entry is {instruction word, its address}
   // ---------------------------------------------------------------------------
   fetch_queue #(
      .WIDTH (2 * WORD_SIZE),
      .DEPTH (DEPTH)
   ) u_fetch_queue (
      .Clk       (Clk),
      .Reset_N   (Reset_N),
      .push      (q_push),
      .push_data ({imem.data1, fetch_pc}),
      .pop       (q_pop),
      .flush     (q_flush),
      .head_data (q_head),
      .count     (q_count)
   );

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign imem.readM1   = (state_q == REQ);
   assign imem.address1 = fetch_pc;
   assign is_halted     = (state_q == HALTED);
   assign inst_valid    = (q_count != '0);
   assign instruction   = q_head[2*WORD_SIZE-1:WORD_SIZE];
   assign inst_pc       = q_head[WORD_SIZE-1:0];
   assign num_inst      = num_inst_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. The main instance uses default parameters
//   (16-bit, DEPTH 4, RESET_PC 0); a second 8-bit, DEPTH 2 instance starting at
//   0xF0 is used to reach the num_inst and fetch_pc wrap points quickly.
//   Memory data for the main instance is address ^ 0xBEEF; for the small one
//   it is address ^ 0x5A. Inputs change and outputs are sampled on negedges.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   logic        Clk = 1'b0;
   logic        Reset_N;

   // Main instance
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        inst_accept;
   logic        halt;
   logic        inst_valid;
   logic [15:0] instruction;
   logic [15:0] inst_pc;
   logic [15:0] num_inst;
   logic        is_halted;

   fetch_unit_if #(.WORD_SIZE(16)) bus ();

   // Small instance for wrap-around checks
   logic        redirect2;
   logic [7:0]  redirect_pc2;
   logic        inst_accept2;
   logic        halt2;
   logic        inst_valid2;
   logic [7:0]  instruction2;
   logic [7:0]  inst_pc2;
   logic [7:0]  num_inst2;
   logic        is_halted2;

   fetch_unit_if #(.WORD_SIZE(8)) bus2 ();

   int n_cmp = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   fetch_unit #(
      .WORD_SIZE (16),
      .DEPTH     (4),
      .RESET_PC  (16'h0000)
   ) dut (
      .Clk         (Clk),
      .Reset_N     (Reset_N),
      .imem        (bus),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .instruction (instruction),
      .inst_pc     (inst_pc),
      .inst_accept (inst_accept),
      .halt        (halt),
      .num_inst    (num_inst),
      .is_halted   (is_halted)
   );

   fetch_unit #(
      .WORD_SIZE (8),
      .DEPTH     (2),
      .RESET_PC  (8'hF0)
   ) dut2 (
      .Clk         (Clk),
      .Reset_N     (Reset_N),
      .imem        (bus2),
      .redirect    (redirect2),
      .redirect_pc (redirect_pc2),
      .inst_valid  (inst_valid2),
      .instruction (instruction2),
      .inst_pc     (inst_pc2),
      .inst_accept (inst_accept2),
      .halt        (halt2),
      .num_inst    (num_inst2),
      .is_halted   (is_halted2)
   );

   // Zero-wait-state memory for the small instance.
   assign bus2.mem_ready = bus2.readM1;
   assign bus2.data1     = bus2.address1 ^ 8'h5A;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   // Called at a negedge; holds reset for one cycle and releases on a negedge.
   task automatic do_reset();
      Reset_N       = 1'b0;
      redirect      = 1'b0;
      redirect_pc   = '0;
      inst_accept   = 1'b0;
      halt          = 1'b0;
      bus.mem_ready = 1'b0;
      bus.data1     = '0;
      tick();
      Reset_N = 1'b1;
   endtask

   // Wait (bounded) for a read request, then check its address.
   task automatic wait_req(input logic [15:0] exp_addr, input string tag);
      int n = 0;
      while (!bus.readM1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_req"}, 32'(bus.readM1), 32'd1);
      check({tag, "_addr"}, 32'(bus.address1), 32'(exp_addr));
   endtask

   // Wait for the request to addr, answer it in the same cycle.
   task automatic serve(input logic [15:0] addr, input string tag);
      wait_req(addr, tag);
      bus.mem_ready = 1'b1;
      bus.data1     = addr ^ 16'hBEEF;
      tick();
      bus.mem_ready = 1'b0;
      bus.data1     = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp_inst [4];
      logic [7:0]  last_pc;
      logic [7:0]  last_inst;
      bit          seen_ff;
      int          n;

      exp_inst = '{16'hBEEF, 16'hBEEE, 16'hBEED, 16'hBEEC};

      redirect2    = 1'b0;
      redirect_pc2 = '0;
      halt2        = 1'b0;
      inst_accept2 = 1'b0;

      // ---------------- reset state ----------------
      Reset_N       = 1'b0;
      redirect      = 1'b0;
      redirect_pc   = '0;
      inst_accept   = 1'b0;
      halt          = 1'b0;
      bus.mem_ready = 1'b0;
      bus.data1     = '0;
      @(negedge Clk);
      check("rst_readM1",    32'(bus.readM1),    32'd0);
      check("rst_address1",  32'(bus.address1),  32'h0000);
      check("rst_valid",     32'(inst_valid),    32'd0);
      check("rst_inst",      32'(instruction),   32'h0000);
      check("rst_pc",        32'(inst_pc),       32'h0000);
      check("rst_num",       32'(num_inst),      32'd0);
      check("rst_halted",    32'(is_halted),     32'd0);
      check("rst2_address1", 32'(bus2.address1), 32'h00F0);
      Reset_N = 1'b1;

      // ---------------- A: streaming, always accept ----------------
      do_reset();
      inst_accept = 1'b1;
      for (int i = 0; i < 4; i++) begin
         serve(16'(i), $sformatf("A%0d", i));
         check($sformatf("A%0d_valid", i), 32'(inst_valid),  32'd1);
         check($sformatf("A%0d_inst", i),  32'(instruction), 32'(exp_inst[i]));
         check($sformatf("A%0d_pc", i),    32'(inst_pc),     32'(i));
         check($sformatf("A%0d_num", i),   32'(num_inst),    32'(i));
      end
      tick();
      check("A_num_final", 32'(num_inst),   32'd4);
      check("A_empty",     32'(inst_valid), 32'd0);

      // ---------------- B: no accept, queue fills ----------------
      do_reset();
      for (int i = 0; i < 4; i++) begin
         serve(16'(i), $sformatf("B%0d", i));
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("B_stall%0d", i), 32'(bus.readM1), 32'd0);
      end
      check("B_head_pc",   32'(inst_pc),     32'h0000);
      check("B_head_inst", 32'(instruction), 32'hBEEF);
      inst_accept = 1'b1;
      tick();
      inst_accept = 1'b0;
      check("B_no_early_req", 32'(bus.readM1), 32'd0);
      check("B_pop_pc",       32'(inst_pc),     32'h0001);
      check("B_pop_inst",     32'(instruction), 32'hBEEE);
      check("B_num",          32'(num_inst),    32'd1);
      wait_req(16'h0004, "B4");

      // ---------------- C: redirect with same-cycle mem_ready ----------------
      do_reset();
      serve(16'h0000, "C0");
      wait_req(16'h0001, "C1");
      bus.mem_ready = 1'b1;
      bus.data1     = 16'h1234;
      redirect      = 1'b1;
      redirect_pc   = 16'h0040;
      tick();
      bus.mem_ready = 1'b0;
      redirect      = 1'b0;
      check("C_flush_valid", 32'(inst_valid), 32'd0);
      check("C_idle",        32'(bus.readM1), 32'd0);
      serve(16'h0040, "C40");
      check("C_head_pc",   32'(inst_pc),     32'h0040);
      check("C_head_inst", 32'(instruction), 32'hBEAF);

      // ---------------- D: halt during a slow request ----------------
      do_reset();
      wait_req(16'h0000, "D0");
      halt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("D_hold_req%0d", i),  32'(bus.readM1), 32'd1);
         check($sformatf("D_not_halt%0d", i),  32'(is_halted),  32'd0);
      end
      bus.mem_ready = 1'b1;
      bus.data1     = 16'hBEEF;
      tick();
      bus.mem_ready = 1'b0;
      check("D_queued_valid", 32'(inst_valid), 32'd1);
      check("D_queued_pc",    32'(inst_pc),    32'h0000);
      check("D_idle_halted",  32'(is_halted),  32'd0);
      tick();
      check("D_halted", 32'(is_halted), 32'd1);
      redirect      = 1'b1;
      redirect_pc   = 16'h0040;
      bus.mem_ready = 1'b1;
      tick();
      redirect      = 1'b0;
      bus.mem_ready = 1'b0;
      check("D_redir_valid", 32'(inst_valid),   32'd1);
      check("D_redir_pc",    32'(bus.address1), 32'h0001);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("D_no_req%0d", i), 32'(bus.readM1), 32'd0);
      end
      inst_accept = 1'b1;
      tick();
      inst_accept = 1'b0;
      check("D_drained", 32'(inst_valid), 32'd0);
      check("D_num",     32'(num_inst),   32'd1);
      halt = 1'b0;
      tick();
      check("D_stay_halted", 32'(is_halted),  32'd1);
      check("D_stay_noreq",  32'(bus.readM1), 32'd0);

      // ---------------- E: asynchronous reset mid-request ----------------
      do_reset();
      serve(16'h0000, "E0");
      wait_req(16'h0001, "E1");
      #2;
      Reset_N = 1'b0;
      #1;
      check("E_async_req",   32'(bus.readM1),   32'd0);
      check("E_async_valid", 32'(inst_valid),   32'd0);
      check("E_async_addr",  32'(bus.address1), 32'h0000);
      check("E_async_inst",  32'(instruction),  32'h0000);
      @(negedge Clk);
      bus.mem_ready = 1'b1;
      bus.data1     = 16'h5555;
      Reset_N       = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      check("E_rel_req",   32'(bus.readM1),   32'd1);
      check("E_rel_addr",  32'(bus.address1), 32'h0000);
      check("E_rel_valid", 32'(inst_valid),   32'd0);

      // ---------------- F: num_inst and fetch_pc wrap (8-bit instance) -------
      inst_accept2 = 1'b1;
      seen_ff      = 1'b0;
      last_pc      = '0;
      last_inst    = '0;
      n            = 0;
      while (n < 2000) begin
         if (num_inst2 == 8'hFF) seen_ff = 1'b1;
         if (seen_ff && num_inst2 == 8'h00) break;
         if (inst_valid2) begin
            last_pc   = inst_pc2;
            last_inst = instruction2;
         end
         tick();
         n++;
      end
      check("F_seen_ff",   32'(seen_ff),   32'd1);
      check("F_wrap",      32'(num_inst2), 32'h00);
      check("F_last_pc",   32'(last_pc),   32'hEF);
      check("F_last_inst", 32'(last_inst), 32'hB5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, 16, instruction/address width.
REQ-002 SHALL have parameter DEPTH, 4, prefetch queue entries (power of 2, >= 2).
REQ-003 SHALL have parameter RESET_PC, 0, first fetch address after reset.
REQ-004 SHALL have port Clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port Reset_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port readM1  out  1  instruction memory read request.
REQ-007 SHALL have port address1  out  WORD_SIZE  fetch address.
REQ-008 SHALL have port mem_ready  in  1  data1 valid this cycle, completing the request.
REQ-009 SHALL have port data1  in  WORD_SIZE  fetched instruction word.
REQ-010 SHALL have port redirect  in  1  branch/jump taken; flush and refetch.
REQ-011 SHALL have port redirect_pc  in  WORD_SIZE  new fetch address.
REQ-012 SHALL have port inst_valid  out  1  queue head valid.
REQ-013 SHALL have port instruction  out  WORD_SIZE  queue head word.
REQ-014 SHALL have port inst_pc  out  WORD_SIZE  address of queue head.
REQ-015 SHALL have port inst_accept  in  1  consumer takes head this cycle.
REQ-016 SHALL have port halt  in  1  stop issuing fetches.
REQ-017 SHALL have port num_inst  out  WORD_SIZE  count of accepted instructions.
REQ-018 SHALL have port is_halted  out  1  fetch unit in HALTED.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, HALTED; readM1 = (state==REQ); is_halted = (state==HALTED).
REQ-020 SHALL hold address1 = fetch_pc stable for the whole of REQ; at most one request outstanding.
REQ-021 SHALL transition IDLE->HALTED when halt=1; else IDLE->REQ when queue count < DEPTH and redirect=0; else stay IDLE.
REQ-022 SHALL, in REQ with mem_ready=1 and redirect=0, push {data1, fetch_pc} into the queue, increment fetch_pc by 1 (modulo 2^WORD_SIZE), and go to IDLE.
REQ-023 SHALL, in REQ with mem_ready=0 and redirect=0, remain in REQ regardless of halt; halt takes effect in the following IDLE.
REQ-024 SHALL, on redirect=1 in IDLE or REQ: clear the queue, load fetch_pc <= redirect_pc, discard any same-cycle mem_ready data, go to IDLE.
REQ-025 SHALL ignore redirect and mem_ready in HALTED; HALTED exits only via reset; queued entries remain consumable.
REQ-026 SHALL drive inst_valid = (count != 0), instruction/inst_pc from head entry; pop when inst_valid && inst_accept.
REQ-027 SHALL keep count unchanged on simultaneous push and pop; pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
REQ-028 SHALL increment num_inst on every pop, including a pop in a redirect cycle, wrapping modulo 2^WORD_SIZE.
REQ-029 SHALL give latency: mem_ready in cycle N -> inst_valid=1 with that word in cycle N+1 if queue was empty.
REQ-030 SHALL never push when full (guaranteed by REQ-021); inst_accept with inst_valid=0 SHALL be ignored.

Reset
REQ-031 SHALL, while Reset_N=0, immediately force state IDLE, fetch_pc=RESET_PC, queue empty, num_inst=0; hence readM1=0, inst_valid=0, is_halted=0.
REQ-032 SHALL abandon an in-flight request on reset; a later mem_ready for it is ignored (state is IDLE).
REQ-033 SHALL reset queue storage contents to 0 so instruction/inst_pc read 0 out of reset.

Structure
REQ-034 SHALL take WORD_SIZE default and FSM state encodings from the shared package/define file used by the CPU.
REQ-035 SHALL instantiate one sub-module fetch_queue: circular FIFO, parametrised WORD_SIZE*2 x DEPTH, with push, pop, flush, count.

Verification
REQ-036 Reset release, mem_ready=1 every REQ, inst_accept=1 -> address1 sequence 0,1,2,...; instruction/inst_pc pairs in order; num_inst increments each accept.
REQ-037 inst_accept=0, DEPTH=4 -> exactly 4 fetches (0..3), then readM1 stays 0; one accept -> fetch of address 4 issued.
REQ-038 redirect=1, redirect_pc=0x0040 in same cycle as mem_ready -> word discarded, inst_valid=0 next cycle, next address1=0x0040.
REQ-039 halt=1 during REQ with mem_ready delayed 3 cycles -> request completes, word queued, then is_halted=1, readM1 never reasserted.
REQ-040 Reset_N=0 mid-REQ -> readM1 drops without clock, count 0; after release, first address1=RESET_PC.
REQ-041 num_inst preset near 0xFFFF via 65536 accepts (or forced) -> wraps to 0x0000 on next accept.
